// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding and the
// command FIFO entry layout.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mosi_width;
    logic [7:0]  miso_width;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);
  localparam int RSP_ENTRY_W = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; contents are only visible once written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds queued SPI commands to the controller over KICK/BUSY and collects
// captured MISO words into a response FIFO.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int CMD_DEPTH_LOG2 = 4,
  parameter int RSP_DEPTH_LOG2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_cmd_we,
  input  logic [31:0]                i_cmd_data,
  input  logic [7:0]                 i_cmd_mosi_width,
  input  logic [7:0]                 i_cmd_miso_width,
  output logic                       o_cmd_full,
  output logic [CMD_DEPTH_LOG2:0]    o_cmd_level,
  input  logic                       i_rsp_re,
  output logic [31:0]                o_rsp_data,
  output logic                       o_rsp_empty,
  output logic [RSP_DEPTH_LOG2:0]    o_rsp_level,
  input  logic                       i_enable,
  output logic                       o_active,
  output logic                       o_kick,
  input  logic                       i_busy,
  output logic [31:0]                o_din,
  output logic [7:0]                 o_mosi_width,
  output logic [7:0]                 o_miso_width,
  input  logic [31:0]                i_dout
);

  localparam int RSP_DEPTH = 1 << RSP_DEPTH_LOG2;

  seq_state_t                r_state;
  seq_state_t                w_state_nxt;
  logic [31:0]               r_din;
  logic [7:0]                r_mosi_width;
  logic [7:0]                r_miso_width;
  logic                      r_need_rsp;

  cmd_entry_t                w_cmd_wdata;
  cmd_entry_t                w_cmd_head;
  logic                      w_cmd_empty;
  logic                      w_cmd_pop;
  logic [RSP_DEPTH_LOG2:0]   w_rsp_level;
  logic                      w_rsp_push;
  logic                      w_rsv;
  logic                      w_rsp_room;
  logic                      w_kick;

  assign w_cmd_wdata = '{data:       i_cmd_data,
                         mosi_width: i_cmd_mosi_width,
                         miso_width: i_cmd_miso_width};

  sync_fifo #(
    .WIDTH      (CMD_ENTRY_W),
    .DEPTH_LOG2 (CMD_DEPTH_LOG2)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_cmd_we),
    .i_data  (w_cmd_wdata),
    .i_pop   (w_cmd_pop),
    .o_data  (w_cmd_head),
    .o_full  (o_cmd_full),
    .o_empty (w_cmd_empty),
    .o_level (o_cmd_level)
  );

  sync_fifo #(
    .WIDTH      (RSP_ENTRY_W),
    .DEPTH_LOG2 (RSP_DEPTH_LOG2)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rsp_push),
    .i_data  (i_dout),
    .i_pop   (i_rsp_re),
    .o_data  (o_rsp_data),
    .o_full  (),
    .o_empty (o_rsp_empty),
    .o_level (w_rsp_level)
  );

  assign o_rsp_level = w_rsp_level;

  // A transfer that will produce a response holds its slot from issue to push,
  // so the WAIT_DONE push can never find the FIFO full.
  assign w_rsv      = r_need_rsp && (r_state != IDLE);
  assign w_rsp_room = (int'(w_rsp_level) + int'(w_rsv)) < RSP_DEPTH;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_pop   = 1'b0;
    w_rsp_push  = 1'b0;
    w_kick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable && !w_cmd_empty &&
            ((w_cmd_head.miso_width == 8'd0) || w_rsp_room)) begin
          w_cmd_pop   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_kick      = 1'b1;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        w_kick = 1'b1;
        if (i_busy) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!i_busy) begin
          w_rsp_push  = r_need_rsp;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_din        <= '0;
      r_mosi_width <= '0;
      r_miso_width <= '0;
      r_need_rsp   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_pop) begin
        r_din        <= w_cmd_head.data;
        r_mosi_width <= w_cmd_head.mosi_width;
        r_miso_width <= w_cmd_head.miso_width;
        r_need_rsp   <= (w_cmd_head.miso_width != 8'd0);
      end
    end
  end

  assign o_kick       = w_kick;
  assign o_active     = (r_state != IDLE);
  assign o_din        = r_din;
  assign o_mosi_width = r_mosi_width;
  assign o_miso_width = r_miso_width;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: controller BFM, queue-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_spi_cmd_sequencer;
  import spi_seq_pkg::*;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] MASK     = 32'hB791_5679;
  localparam int          BUSY_LEN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [7:0]  cmd_mw = '0;
  logic [7:0]  cmd_sw = '0;
  logic        cmd_full;
  logic [4:0]  cmd_level;
  logic        rsp_re = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_empty;
  logic [4:0]  rsp_level;
  logic        enable = 1'b0;
  logic        active;
  logic        kick;
  logic        busy;
  logic [31:0] din;
  logic [7:0]  mosi_w;
  logic [7:0]  miso_w;
  logic [31:0] dout;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(.CMD_DEPTH_LOG2(4), .RSP_DEPTH_LOG2(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_cmd_we         (cmd_we),
    .i_cmd_data       (cmd_data),
    .i_cmd_mosi_width (cmd_mw),
    .i_cmd_miso_width (cmd_sw),
    .o_cmd_full       (cmd_full),
    .o_cmd_level      (cmd_level),
    .i_rsp_re         (rsp_re),
    .o_rsp_data       (rsp_data),
    .o_rsp_empty      (rsp_empty),
    .o_rsp_level      (rsp_level),
    .i_enable         (enable),
    .o_active         (active),
    .o_kick           (kick),
    .i_busy           (busy),
    .o_din            (din),
    .o_mosi_width     (mosi_w),
    .o_miso_width     (miso_w),
    .i_dout           (dout)
  );

  // Controller model: edge register resets to 1, BUSY follows a KICK rise,
  // DOUT (DIN xor MASK) is valid when BUSY falls and held until the next kick.
  logic        bfm_kick_q;
  int          bfm_cnt;
  logic [31:0] bfm_din;
  always @(posedge clk) begin
    if (reset) begin
      bfm_kick_q <= 1'b1;
      busy       <= 1'b0;
      bfm_cnt    <= 0;
      dout       <= '0;
    end else begin
      bfm_kick_q <= kick;
      if (kick && !bfm_kick_q && !busy) begin
        busy    <= 1'b1;
        bfm_cnt <= BUSY_LEN;
        bfm_din <= din;
      end else if (busy) begin
        if (bfm_cnt == 0) begin
          busy <= 1'b0;
          dout <= bfm_din ^ MASK;
        end else begin
          bfm_cnt <= bfm_cnt - 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_print  = 0;
  int kick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_print < 60) begin
        n_print++;
        $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: command/response queues plus in-flight transfer.
  cmd_entry_t  m_cmdq[$];
  logic [31:0] m_rspq[$];
  cmd_entry_t  m_cur;
  bit          m_active    = 1'b0;
  bit          prev_kick   = 1'b0;
  bit          prev_busy   = 1'b0;
  bit          prev_enable = 1'b0;
  int          prev_rsp_size = 0;

  always @(negedge clk) begin
    bit         k_rise;
    bit         b_fall;
    cmd_entry_t e;
    k_rise = kick && !prev_kick;
    b_fall = !busy && prev_busy;

    if (k_rise) begin
      kick_cnt++;
      check("cmd_avail_at_kick", 32'(m_cmdq.size() != 0), 32'd1);
      if (m_cmdq.size() != 0) begin
        m_cur    = m_cmdq.pop_front();
        m_active = 1'b1;
        check("din", din, m_cur.data);
        check("mosi_width", 32'(mosi_w), 32'(m_cur.mosi_width));
        check("miso_width", 32'(miso_w), 32'(m_cur.miso_width));
        check("issue_while_enabled", 32'(prev_enable), 32'd1);
        if (m_cur.miso_width != 8'd0)
          check("issue_with_rsp_room", 32'(prev_rsp_size < DEPTH), 32'd1);
      end
    end

    check("cmd_level", 32'(cmd_level), 32'(m_cmdq.size()));
    check("cmd_full", 32'(cmd_full), 32'(m_cmdq.size() == DEPTH));
    check("rsp_level", 32'(rsp_level), 32'(m_rspq.size()));
    check("rsp_empty", 32'(rsp_empty), 32'(m_rspq.size() == 0));
    if (m_rspq.size() != 0) check("rsp_data", rsp_data, m_rspq[0]);
    check("active", 32'(active), 32'(m_active));
    if (prev_busy) check("kick_low_after_busy", 32'(kick), 32'd0);

    prev_rsp_size = m_rspq.size();
    if (reset) begin
      m_cmdq.delete();
      m_rspq.delete();
      m_active    = 1'b0;
      prev_kick   = 1'b0;
      prev_busy   = 1'b0;
      prev_enable = 1'b0;
    end else begin
      if (rsp_re && m_rspq.size() != 0) void'(m_rspq.pop_front());
      if (b_fall) begin
        if (m_cur.miso_width != 8'd0) m_rspq.push_back(m_cur.data ^ MASK);
        m_active = 1'b0;
      end
      if (cmd_we && m_cmdq.size() < DEPTH) begin
        e.data       = cmd_data;
        e.mosi_width = cmd_mw;
        e.miso_width = cmd_sw;
        m_cmdq.push_back(e);
      end
      prev_kick   = kick;
      prev_busy   = busy;
      prev_enable = enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] d, input logic [7:0] mw, input logic [7:0] sw);
    cmd_we   = 1'b1;
    cmd_data = d;
    cmd_mw   = mw;
    cmd_sw   = sw;
    tick();
    cmd_we   = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_re = 1'b1;
    tick();
    rsp_re = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((m_cmdq.size() != 0 || m_active) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_kick", 32'(kick), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_mosi", 32'(mosi_w), 32'd0);
    check("rst_miso", 32'(miso_w), 32'd0);
    check("rst_cmd_full", 32'(cmd_full), 32'd0);
    check("rst_rsp_empty", 32'(rsp_empty), 32'd1);
    check("rst_cmd_level", 32'(cmd_level), 32'd0);
    check("rst_rsp_level", 32'(rsp_level), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    // Single command with response
    push_cmd(32'hA5A5_0001, 8'd32, 8'd32);
    wait_quiet(50, "t1_timeout");
    check("t1_rsp_data", rsp_data, 32'h1234_5678);
    check("t1_rsp_level", 32'(rsp_level), 32'd1);
    check("t1_active", 32'(active), 32'd0);
    check("t1_kicks", 32'(kick_cnt), 32'd1);
    pop_rsp();
    check("t1_rsp_empty", 32'(rsp_empty), 32'd1);

    // Three back-to-back commands, miso 0/8/16
    k0 = kick_cnt;
    push_cmd(32'h0000_0011, 8'd8, 8'd0);
    push_cmd(32'h0000_0022, 8'd8, 8'd8);
    push_cmd(32'h0000_0033, 8'd16, 8'd16);
    wait_quiet(100, "t2_timeout");
    check("t2_kicks", 32'(kick_cnt - k0), 32'd3);
    check("t2_rsp_level", 32'(rsp_level), 32'd2);
    check("t2_rsp0", rsp_data, 32'hB791_565B);
    pop_rsp();
    check("t2_rsp1", rsp_data, 32'hB791_564A);
    pop_rsp();

    // Fill command FIFO with 17 writes while held
    enable = 1'b0;
    tick();
    k0 = kick_cnt;
    for (int i = 0; i < 17; i++) begin
      push_cmd(32'h0000_0100 + 32'(i), 8'd8, 8'd8);
      if (i == 14) check("t3_not_full_15", 32'(cmd_full), 32'd0);
      if (i == 15) check("t3_full_16", 32'(cmd_full), 32'd1);
    end
    check("t3_level", 32'(cmd_level), 32'd16);
    check("t3_full", 32'(cmd_full), 32'd1);
    check("t3_no_kick", 32'(kick_cnt - k0), 32'd0);
    enable = 1'b1;
    wait_quiet(400, "t3_timeout");
    check("t3_kicks", 32'(kick_cnt - k0), 32'd16);
    check("t3_rsp_level", 32'(rsp_level), 32'd16);
    check("t3_rsp_head", rsp_data, 32'hB791_5779);

    // Response FIFO full blocks a miso>0 command until a pop
    k0 = kick_cnt;
    push_cmd(32'hCAFE_0000, 8'd16, 8'd32);
    repeat (20) tick();
    check("t4_blocked_kicks", 32'(kick_cnt - k0), 32'd0);
    check("t4_cmd_level", 32'(cmd_level), 32'd1);
    check("t4_active", 32'(active), 32'd0);
    pop_rsp();
    wait_quiet(50, "t4_timeout");
    check("t4_kicks", 32'(kick_cnt - k0), 32'd1);
    check("t4_rsp_level", 32'(rsp_level), 32'd16);
    repeat (15) pop_rsp();
    check("t4_last_rsp", rsp_data, 32'h7D6F_5679);
    pop_rsp();
    check("t4_drained", 32'(rsp_empty), 32'd1);

    // ENABLE dropped during WAIT_DONE
    k0 = kick_cnt;
    push_cmd(32'h5555_AAAA, 8'd32, 8'd16);
    push_cmd(32'h6666_0000, 8'd32, 8'd16);
    n = 0;
    while (!(kick_cnt == k0 + 1 && busy && !kick) && n < 50) begin
      tick();
      n++;
    end
    check("t5_reach_wait_done", 32'(n < 50), 32'd1);
    enable = 1'b0;
    n = 0;
    while (active && n < 50) begin
      tick();
      n++;
    end
    check("t5_finish_timeout", 32'(n < 50), 32'd1);
    repeat (15) tick();
    check("t5_held_kicks", 32'(kick_cnt - k0), 32'd1);
    check("t5_cmd_level", 32'(cmd_level), 32'd1);
    check("t5_rsp_level", 32'(rsp_level), 32'd1);
    check("t5_rsp0", rsp_data, 32'hE2C4_FCD3);
    enable = 1'b1;
    wait_quiet(50, "t5_timeout");
    check("t5_kicks", 32'(kick_cnt - k0), 32'd2);
    check("t5_rsp_level2", 32'(rsp_level), 32'd2);
    pop_rsp();
    pop_rsp();

    // RESET during WAIT_BUSY flushes everything
    push_cmd(32'h7777_0001, 8'd8, 8'd8);
    wait_quiet(50, "t6_pre_timeout");
    push_cmd(32'h8888_0002, 8'd8, 8'd8);
    push_cmd(32'h9999_0003, 8'd8, 8'd8);
    n = 0;
    while (!(kick && busy) && n < 50) begin
      tick();
      n++;
    end
    check("t6_reach_wait_busy", 32'(n < 50), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_kick", 32'(kick), 32'd0);
    check("t6_active", 32'(active), 32'd0);
    check("t6_cmd_level", 32'(cmd_level), 32'd0);
    check("t6_rsp_level", 32'(rsp_level), 32'd0);
    check("t6_rsp_empty", 32'(rsp_empty), 32'd1);
    reset = 1'b0;
    tick();

    // Sequencer works again after reset
    k0 = kick_cnt;
    push_cmd(32'h0BAD_F00D, 8'd32, 8'd32);
    wait_quiet(50, "t7_timeout");
    check("t7_kicks", 32'(kick_cnt - k0), 32'd1);
    check("t7_rsp", rsp_data, 32'hBC3C_A674);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
